// File: rtl/shifter_sll_seq.sv
// Multi-cycle logical-left shifter (SLL) with a start/busy/done handshake.
// It is the left-shift counterpart of the ALU SRL path and feeds the same result mux.
// dataA is the value, dataB[SHAMT_W-1:0] is the shift amount and Signal is the 6-bit function code.
// Optional feature: define SHIFTER_STEP4_EN to shift 4 bits per cycle while the
// remaining count is at least 4. Results are the same in both builds; only latency changes.
module shifter_sll_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter logic [5:0]  SLL     = 6'b000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]         state,   state_nxt;
    logic [WIDTH-1:0]   sreg,    sreg_nxt;
    logic [SHAMT_W-1:0] cnt,     cnt_nxt;
    logic [5:0]         op,      op_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [WIDTH-1:0]   dout_nxt;

    logic [WIDTH-1:0]   step_sreg;
    logic [SHAMT_W-1:0] step_cnt;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_is_sll;

    assign in_shamt  = dataB[SHAMT_W-1:0];
    assign in_is_sll = (Signal == SLL);

    // Upper shift-amount bits are intentionally ignored.
    generate
        if (WIDTH > SHAMT_W) begin : g_unused_b
            logic unused_b_hi;
            assign unused_b_hi = ^dataB[WIDTH-1:SHAMT_W];
        end
    endgenerate

    // One shift step: the shifted value and the remaining count after this cycle.
    always_comb begin
        step_sreg = sreg << 1;
        step_cnt  = cnt - SHAMT_W'(1);
`ifdef SHIFTER_STEP4_EN
        if (32'(cnt) >= 32'd4) begin
            step_sreg = sreg << 4;
            step_cnt  = cnt - SHAMT_W'(4);
        end
`endif
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        op_nxt    = op;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        dout_nxt  = dataOut;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    sreg_nxt = dataA;
                    cnt_nxt  = in_shamt;
                    op_nxt   = Signal;
                    if (in_is_sll && (in_shamt != '0)) begin
                        state_nxt = ST_BUSY;
                        busy_nxt  = 1'b1;
                    end else begin
                        // Zero shift or unsupported code finishes straight away.
                        state_nxt = ST_FIN;
                        done_nxt  = 1'b1;
                        dout_nxt  = in_is_sll ? dataA : '0;
                    end
                end
            end
            ST_BUSY: begin
                sreg_nxt = step_sreg;
                cnt_nxt  = step_cnt;
                if (step_cnt == '0) begin
                    state_nxt = ST_FIN;
                    done_nxt  = 1'b1;
                    dout_nxt  = (op == SLL) ? step_sreg : '0;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            ST_FIN: begin
                // Any start seen here is dropped; the next one is taken from IDLE.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            cnt     <= '0;
            op      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= '0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            cnt     <= cnt_nxt;
            op      <= op_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            dataOut <= dout_nxt;
        end
    end

endmodule
